// File: rtl/wb_trace_serializer.sv
// Dual-slot writeback trace FIFO: captures up to two register-write records per
// cycle in program order and presents them one at a time on a ready/valid port.
module wb_trace_serializer #(
    parameter int DEPTH = 8
) (
    input  logic                    sys_clk,
    input  logic                    resetn,
    input  logic                    wb0_en,
    input  logic [4:0]              wb0_rd,
    input  logic [31:0]             wb0_wdata,
    input  logic [31:0]             wb0_pc,
    input  logic                    wb1_en,
    input  logic [4:0]              wb1_rd,
    input  logic [31:0]             wb1_wdata,
    input  logic [31:0]             wb1_pc,
    output logic                    wb_stall,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [4:0]              out_rd,
    output logic [31:0]             out_wdata,
    output logic                    out_slot,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level,
    output logic [31:0]             commit_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 32 + 5 + 32 + 1;

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          overflow_reg;
    logic [31:0]   commit_cnt_reg;

    logic          en_in    [2];
    logic [4:0]    rd_in    [2];
    logic [31:0]   wdata_in [2];
    logic [31:0]   pc_in    [2];
    logic [1:0]    slot_valid;
    logic [RW-1:0] slot_rec [2];

    assign en_in[0]    = wb0_en;
    assign en_in[1]    = wb1_en;
    assign rd_in[0]    = wb0_rd;
    assign rd_in[1]    = wb1_rd;
    assign wdata_in[0] = wb0_wdata;
    assign wdata_in[1] = wb1_wdata;
    assign pc_in[0]    = wb0_pc;
    assign pc_in[1]    = wb1_pc;

    // Writes to x0 are architecturally invisible, so they never enter the trace.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_valid[gi] = en_in[gi] && (rd_in[gi] != 5'd0);
            assign slot_rec[gi]   = {pc_in[gi], rd_in[gi], wdata_in[gi], 1'(gi)};
        end
    endgenerate

    logic          pop;
    logic [LW-1:0] free_cnt;
    logic [LW-1:0] avail;
    logic          acc0;
    logic          acc1;
    logic          drop;
    logic [1:0]    n_push;
    logic [AW-1:0] wr_addr1;
    logic [LW-1:0] level_next;

    assign free_cnt = LW'(DEPTH) - level_reg;
    assign pop      = (level_reg != '0) && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still take one record.
    assign avail    = free_cnt + LW'(pop);
    assign acc0     = slot_valid[0] && (avail >= LW'(1));
    assign acc1     = slot_valid[1] && (avail >= (acc0 ? LW'(2) : LW'(1)));
    assign drop     = (slot_valid[0] && !acc0) || (slot_valid[1] && !acc1);
    assign n_push   = {1'b0, acc0} + {1'b0, acc1};
    assign wr_addr1 = wr_ptr_reg + AW'(acc0);
    assign level_next = level_reg + LW'(n_push) - LW'(pop);

    always_ff @(posedge sys_clk) begin
        if (resetn) begin
            if (acc0) mem[wr_ptr_reg] <= slot_rec[0];
            if (acc1) mem[wr_addr1]   <= slot_rec[1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            level_reg      <= '0;
            overflow_reg   <= 1'b0;
            commit_cnt_reg <= '0;
        end else begin
            rd_ptr_reg     <= rd_ptr_reg + AW'(pop);
            wr_ptr_reg     <= wr_ptr_reg + AW'(n_push);
            level_reg      <= level_next;
            overflow_reg   <= overflow_reg | drop;
            commit_cnt_reg <= commit_cnt_reg + 32'(n_push);
        end
    end

    assign {out_pc, out_rd, out_wdata, out_slot} = mem[rd_ptr_reg];
    assign out_valid  = (level_reg != '0);
    assign wb_stall   = (free_cnt < LW'(2));
    assign overflow   = overflow_reg;
    assign level      = level_reg;
    assign commit_cnt = commit_cnt_reg;
endmodule

// File: tb/tb_wb_trace_serializer.sv
// Randomised and directed bench for wb_trace_serializer against a queue-based
// model of the trace FIFO.
module tb_wb_trace_serializer;
    localparam int DEPTH = 8;

    logic        sys_clk, resetn;
    logic        wb0_en, wb1_en;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_wdata, wb1_wdata, wb0_pc, wb1_pc;
    logic        wb_stall, out_valid, out_ready, out_slot, overflow;
    logic [31:0] out_pc, out_wdata, commit_cnt;
    logic [4:0]  out_rd;
    logic [3:0]  level;

    wb_trace_serializer #(.DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .resetn(resetn),
        .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_wdata(wb0_wdata), .wb0_pc(wb0_pc),
        .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_wdata(wb1_wdata), .wb1_pc(wb1_pc),
        .wb_stall(wb_stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_wdata(out_wdata), .out_slot(out_slot),
        .overflow(overflow), .level(level), .commit_cnt(commit_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        slot;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_cnt;
    logic        m_ovf;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic drive(input logic e0, input logic [4:0] r0, input logic [31:0] p0,
                         input logic e1, input logic [4:0] r1, input logic [31:0] p1,
                         input logic rdy);
        wb0_en = e0; wb0_rd = r0; wb0_pc = p0; wb0_wdata = p0 ^ 32'h5a5a0000;
        wb1_en = e1; wb1_rd = r1; wb1_pc = p1; wb1_wdata = p1 ^ 32'h0000a5a5;
        out_ready = rdy;
    endtask

    task automatic model_push(input logic en, input logic [4:0] rd, input logic [31:0] pc,
                              input logic [31:0] wd, input logic slot);
        rec_t r;
        if (en && rd != 5'd0) begin
            if (q.size() < DEPTH) begin
                r.pc = pc; r.rd = rd; r.wdata = wd; r.slot = slot;
                q.push_back(r);
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // One clock: advance the model with the inputs now on the pins, then compare.
    task automatic cyc();
        rec_t h;
        if (!resetn) begin
            q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            model_push(wb0_en, wb0_rd, wb0_pc, wb0_wdata, 1'b0);
            model_push(wb1_en, wb1_rd, wb1_pc, wb1_wdata, 1'b1);
        end
        @(posedge sys_clk);
        #1;
        check_val("level", 64'(level), 64'(q.size()));
        check_val("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check_val("wb_stall", 64'(wb_stall), 64'((DEPTH - q.size()) < 2));
        check_val("overflow", 64'(overflow), 64'(m_ovf));
        check_val("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
        if (q.size() != 0) begin
            h = q[0];
            check_val("head", {out_pc, out_rd, out_wdata, out_slot}, 64'(h) | (64'(h) & 0));
            check_val("out_pc", 64'(out_pc), 64'(h.pc));
            check_val("out_slot", 64'(out_slot), 64'(h.slot));
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b1, 5'd7, 32'hdead0000, 1'b1, 5'd8, 32'hdead0004, 1'b1);
        cyc();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        do_reset();
        do_reset();
        check_val("rst_level", 64'(level), 64'd0);
        check_val("rst_valid", 64'(out_valid), 64'd0);

        // Dual push, then pop one
        drive(1'b1, 5'd3, 32'hbfc00000, 1'b1, 5'd4, 32'hbfc00004, 1'b0);
        cyc();
        check_val("dual_level", 64'(level), 64'd2);
        check_val("dual_pc0", 64'(out_pc), 64'hbfc00000);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        cyc();
        check_val("pop_pc1", 64'(out_pc), 64'hbfc00004);
        check_val("pop_slot1", 64'(out_slot), 64'd1);
        check_val("dual_cnt", 64'(commit_cnt), 64'd2);

        // Filtering: rd=0 and en=0 both ignored
        drive(1'b1, 5'd0, 32'h100, 1'b0, 5'd5, 32'h104, 1'b0);
        cyc();
        check_val("filt_cnt", 64'(commit_cnt), 64'd2);

        // Fill to full, then overflow, then full with concurrent pop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(i + 1), 32'h1000 + 32'(8 * i), 1'b1, 5'(i + 9), 32'h1004 + 32'(8 * i), 1'b0);
            cyc();
        end
        check_val("fill_cnt", 64'(commit_cnt), 64'd8);
        check_val("fill_ovf", 64'(overflow), 64'd1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'h2000 + 32'(8 * i), 1'b1, 5'd2, 32'h2004 + 32'(8 * i), 1'b0);
            cyc();
        end
        drive(1'b1, 5'd3, 32'h3000, 1'b1, 5'd4, 32'h3004, 1'b1);
        cyc();
        check_val("fullpop_level", 64'(level), 64'd8);
        check_val("fullpop_ovf", 64'(overflow), 64'd1);

        // Wrap-around with continuous consumer
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd9, 32'h4000 + 32'(4 * i), 1'b0, 5'd0, 32'h0, 1'b1);
            cyc();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        cyc();
        check_val("wrap_level", 64'(level), 64'd0);
        check_val("wrap_ovf", 64'(overflow), 64'd0);

        // Reset with records queued
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd6, 32'h5000 + 32'(4 * i), 1'b0, 5'd0, 32'h0, 1'b0);
            cyc();
        end
        do_reset();
        check_val("rst5_level", 64'(level), 64'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h6000, 1'b0);
        cyc();
        check_val("rst5_pc", 64'(out_pc), 64'h6000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 2) != 0);
            cyc();
        end
        resetn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_trace_serializer.md
WB_TRACE_SERIALIZER -- requirements
Module: wb_trace_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, minimum 4.
REQ-002 SHALL have port sys_clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port wb0_en  input  1  slot-0 writeback register-write enable.
REQ-005 SHALL have port wb0_rd  input  5  slot-0 destination register number.
REQ-006 SHALL have port wb0_wdata  input  32  slot-0 write data.
REQ-007 SHALL have port wb0_pc  input  32  slot-0 instruction PC.
REQ-008 SHALL have ports wb1_en/wb1_rd/wb1_wdata/wb1_pc  input  1/5/32/32  slot-1 equivalents; slot 1 is younger than slot 0.
REQ-009 SHALL have port wb_stall  output  1  high when fewer than 2 entries are free.
REQ-010 SHALL have port out_valid  output  1  head record available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head record.
REQ-012 SHALL have ports out_pc/out_rd/out_wdata/out_slot  output  32/5/32/1  head record fields; out_slot is the originating slot.
REQ-013 SHALL have port overflow  output  1  sticky; a valid record was dropped.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port commit_cnt  output  32  total records accepted.

Function
REQ-016 A slot record SHALL be valid iff en=1 and rd!=0; invalid records are discarded silently, not counted.
REQ-017 Records SHALL be enqueued in program order: slot 0 before slot 1 within a cycle; both valid -> two entries in one cycle at wr_ptr and wr_ptr+1.
REQ-018 Only slot 1 valid -> single entry at wr_ptr, out_slot field = 1.
REQ-019 Pop SHALL occur when out_valid=1 and out_ready=1; head advances by one; rd_ptr wraps modulo DEPTH.
REQ-020 Capacity per cycle SHALL be avail = (DEPTH - level) + pop; simultaneous push and pop at full is legal.
REQ-021 Pushes exceeding avail: accept oldest records first (slot 0 before slot 1), drop remainder, set overflow next cycle; overflow holds until reset.
REQ-022 level SHALL update to level + accepted_pushes - pop each cycle; never exceed DEPTH, never underflow.
REQ-023 out_valid SHALL equal (level != 0); out_* fields SHALL reflect the head entry combinationally from storage; write-to-read latency 1 cycle (record written at edge N visible after edge N).
REQ-024 out_* fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 wb_stall SHALL equal ((DEPTH - level) < 2), derived from the registered level only, no dependence on out_ready.
REQ-026 commit_cnt SHALL increment by accepted_pushes (0, 1 or 2) each cycle, wrapping modulo 2^32.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 resetn=0 at a rising edge SHALL clear rd_ptr, wr_ptr, level, overflow, commit_cnt to 0; out_valid=0, wb_stall=0 next cycle.
REQ-029 Storage contents need not be reset; out_pc/out_rd/out_wdata/out_slot are don't-care while out_valid=0.
REQ-030 Reset mid-operation SHALL discard all queued records; writeback inputs sampled during the reset cycle are ignored.

Verification
REQ-031 Dual push: wb0(en=1,rd=3,wdata=0x11,pc=0xbfc00000), wb1(en=1,rd=4,wdata=0x22,pc=0xbfc00004), out_ready=0 -> level=2, head pc=0xbfc00000 slot 0; after one pop head pc=0xbfc00004 slot 1; commit_cnt=2.
REQ-032 Filtering: wb0(en=1,rd=0), wb1(en=0,rd=5) -> no push, level unchanged, commit_cnt unchanged.
REQ-033 Fill: DEPTH=8, out_ready=0, 4 cycles of dual pushes -> level=8, wb_stall=1 from level=7; fifth dual push -> both dropped, overflow=1, commit_cnt=8.
REQ-034 Full with concurrent pop: level=8, out_ready=1, dual push -> slot 0 accepted, slot 1 dropped, level=8, overflow=1.
REQ-035 Wrap-around: 20 single pushes with out_ready=1 continuously -> 20 records emitted in order, pc sequence matches input, level returns to 0, overflow=0.
REQ-036 Reset at level=5 -> next cycle level=0, out_valid=0, commit_cnt=0, overflow=0; subsequent push emerges correctly.
